// File: rtl/traffic_light_monitor.sv
// Passive lamp-output watchdog: decodes traffic-light phases, times them and flags
// illegal codes, illegal transitions, bad blink patterns and wrong phase lengths.
//   state          | meaning
//   ST_UNKNOWN (0) | not synchronised, waiting for the first red code
//   ST_RED     (1) | red lamp only
//   ST_YR      (2) | red plus yellow
//   ST_GREEN   (3) | steady green, no off sample yet in this group
//   ST_BLINK   (4) | green blinking, on/off must alternate every cycle
//   ST_YELLOW  (5) | yellow lamp only
module traffic_light_monitor #(
    parameter int PERIOD_RED        = 3,
    parameter int PERIOD_YELLOW_RED = 3,
    parameter int PERIOD_GREEN      = 3,
    parameter int PERIOD_BLINK      = 3,
    parameter int PERIOD_YELLOW     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        red_i,
    input  logic        yellow_i,
    input  logic        green_i,
    output logic [2:0]  phase_o,
    output logic        seq_err_o,
    output logic        dur_err_o,
    output logic        cycle_done_o,
    output logic [10:0] last_dur_o,
    output logic [7:0]  err_count_o
);

    localparam logic [2:0] ST_UNKNOWN = 3'd0;
    localparam logic [2:0] ST_RED     = 3'd1;
    localparam logic [2:0] ST_YR      = 3'd2;
    localparam logic [2:0] ST_GREEN   = 3'd3;
    localparam logic [2:0] ST_BLINK   = 3'd4;
    localparam logic [2:0] ST_YELLOW  = 3'd5;

    localparam logic [2:0] C_RED  = 3'b100;
    localparam logic [2:0] C_YR   = 3'b110;
    localparam logic [2:0] C_GON  = 3'b001;
    localparam logic [2:0] C_GOFF = 3'b000;
    localparam logic [2:0] C_YEL  = 3'b010;

    localparam logic [10:0] CNT_MAX   = 11'h7FF;
    localparam logic [10:0] EXP_RED   = 11'(PERIOD_RED);
    localparam logic [10:0] EXP_YR    = 11'(PERIOD_YELLOW_RED);
    localparam logic [10:0] EXP_GROUP = 11'(PERIOD_GREEN + PERIOD_BLINK);
    localparam logic [10:0] EXP_YEL   = 11'(PERIOD_YELLOW);
    localparam bit          BLINK_REQUIRED = (PERIOD_BLINK >= 2);

    logic [2:0]  code;
    logic [2:0]  phase_q, phase_d, succ;
    logic        armed_q, armed_d;
    logic        cycle_ok_q, cycle_ok_d;
    logic        blink_on_q, blink_on_d;
    logic [10:0] cnt_q, cnt_d, cnt_inc, exp_len;
    logic        seq_err_d, dur_err_d, done_d;
    logic [10:0] last_dur_d;
    logic [7:0]  err_cnt_d;
    logic        stay, adv, mismatch;

    assign code     = {red_i, yellow_i, green_i};
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 11'd1;
    assign mismatch = (cnt_q != exp_len);

    always_comb begin
        stay    = 1'b0;
        adv     = 1'b0;
        succ    = ST_UNKNOWN;
        exp_len = '0;
        case (phase_q)
            ST_RED: begin
                stay = (code == C_RED);  adv = (code == C_YR);  succ = ST_YR;     exp_len = EXP_RED;
            end
            ST_YR: begin
                stay = (code == C_YR);   adv = (code == C_GON); succ = ST_GREEN;  exp_len = EXP_YR;
            end
            ST_GREEN: begin
                stay = (code == C_GON) || (code == C_GOFF);
                adv  = (code == C_YEL) && !BLINK_REQUIRED;
                succ = ST_YELLOW;  exp_len = EXP_GROUP;
            end
            ST_BLINK: begin
                stay = blink_on_q ? (code == C_GOFF) : (code == C_GON);
                adv  = (code == C_YEL);  succ = ST_YELLOW;  exp_len = EXP_GROUP;
            end
            ST_YELLOW: begin
                stay = (code == C_YEL);  adv = (code == C_RED); succ = ST_RED;    exp_len = EXP_YEL;
            end
            default: ;
        endcase
    end

    always_comb begin
        phase_d    = phase_q;
        armed_d    = armed_q;
        cnt_d      = cnt_q;
        cycle_ok_d = cycle_ok_q;
        blink_on_d = blink_on_q;
        seq_err_d  = 1'b0;
        dur_err_d  = 1'b0;
        done_d     = 1'b0;
        last_dur_d = last_dur_o;
        if (phase_q == ST_UNKNOWN) begin
            if (code == C_RED) begin
                phase_d    = ST_RED;
                armed_d    = 1'b0;
                cnt_d      = 11'd1;
                cycle_ok_d = 1'b0;
            end
        end else if (stay) begin
            cnt_d = cnt_inc;
            // GREEN and BLINK share one duration count across the whole green group
            if (phase_q == ST_GREEN && code == C_GOFF) begin
                phase_d    = ST_BLINK;
                blink_on_d = 1'b0;
            end else if (phase_q == ST_BLINK) begin
                blink_on_d = !blink_on_q;
            end
        end else if (adv) begin
            phase_d = succ;
            armed_d = 1'b1;
            cnt_d   = 11'd1;
            if (armed_q) begin
                last_dur_d = cnt_q;
                dur_err_d  = mismatch;
            end
            if (phase_q == ST_YELLOW) begin
                done_d     = cycle_ok_q && armed_q && !mismatch;
                cycle_ok_d = 1'b1;
            end else if (armed_q && mismatch) begin
                cycle_ok_d = 1'b0;
            end
        end else begin
            seq_err_d  = 1'b1;
            phase_d    = ST_UNKNOWN;
            armed_d    = 1'b0;
            cnt_d      = '0;
            cycle_ok_d = 1'b0;
        end
        err_cnt_d = ((seq_err_d || dur_err_d) && err_count_o != 8'hFF) ? err_count_o + 8'd1
                                                                        : err_count_o;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q      <= ST_UNKNOWN;
            armed_q      <= 1'b0;
            cnt_q        <= '0;
            cycle_ok_q   <= 1'b0;
            blink_on_q   <= 1'b0;
            seq_err_o    <= 1'b0;
            dur_err_o    <= 1'b0;
            cycle_done_o <= 1'b0;
            last_dur_o   <= '0;
            err_count_o  <= '0;
        end else begin
            phase_q      <= phase_d;
            armed_q      <= armed_d;
            cnt_q        <= cnt_d;
            cycle_ok_q   <= cycle_ok_d;
            blink_on_q   <= blink_on_d;
            seq_err_o    <= seq_err_d;
            dur_err_o    <= dur_err_d;
            cycle_done_o <= done_d;
            last_dur_o   <= last_dur_d;
            err_count_o  <= err_cnt_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: a behavioural phase model queues the
// expected outputs for every lamp code driven; the sample after the clock pops and compares.
module tb_traffic_light_monitor;

    localparam int P_R = 3, P_YR = 3, P_G = 3, P_B = 3, P_Y = 3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        red_i = 1'b0, yellow_i = 1'b0, green_i = 1'b0;
    logic [2:0]  phase_o;
    logic        seq_err_o, dur_err_o, cycle_done_o;
    logic [10:0] last_dur_o;
    logic [7:0]  err_count_o;

    traffic_light_monitor #(
        .PERIOD_RED(P_R), .PERIOD_YELLOW_RED(P_YR), .PERIOD_GREEN(P_G),
        .PERIOD_BLINK(P_B), .PERIOD_YELLOW(P_Y)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .red_i(red_i), .yellow_i(yellow_i), .green_i(green_i),
        .phase_o(phase_o), .seq_err_o(seq_err_o), .dur_err_o(dur_err_o),
        .cycle_done_o(cycle_done_o), .last_dur_o(last_dur_o), .err_count_o(err_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int phase; int seq; int dur; int done; int last; int errc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0, done_seen = 0;

    // reference model state
    int m_phase = 0, m_cnt = 0, m_armed = 0, m_ok = 0, m_on = 0, m_last = 0, m_errs = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_armed = 0; m_ok = 0; m_on = 0; m_last = 0; m_errs = 0;
    endtask

    task automatic model(input logic [2:0] c, output exp_t e);
        int seq = 0, dur = 0, done = 0, hold = 0, step = 0, nxt = 0, want = 0;
        if (m_phase == 0) begin
            if (c == 3'b100) begin m_phase = 1; m_armed = 0; m_cnt = 1; m_ok = 0; end
        end else begin
            case (m_phase)
                1: begin hold = (c == 3'b100); step = (c == 3'b110); nxt = 2; want = P_R; end
                2: begin hold = (c == 3'b110); step = (c == 3'b001); nxt = 3; want = P_YR; end
                3: begin hold = (c == 3'b001 || c == 3'b000); step = (c == 3'b010 && P_B < 2);
                         nxt = 5; want = P_G + P_B; end
                4: begin hold = m_on ? (c == 3'b000) : (c == 3'b001); step = (c == 3'b010);
                         nxt = 5; want = P_G + P_B; end
                default: begin hold = (c == 3'b010); step = (c == 3'b100); nxt = 1; want = P_Y; end
            endcase
            if (hold) begin
                if (m_cnt < 2047) m_cnt++;
                if (m_phase == 3 && c == 3'b000) begin m_phase = 4; m_on = 0; end
                else if (m_phase == 4) m_on = 1 - m_on;
            end else if (step) begin
                if (m_armed) begin m_last = m_cnt; dur = (m_cnt != want); end
                if (m_phase == 5) begin done = m_ok && m_armed && !dur; m_ok = 1; end
                else if (dur) m_ok = 0;
                m_phase = nxt; m_armed = 1; m_cnt = 1;
            end else begin
                seq = 1; m_phase = 0; m_armed = 0; m_cnt = 0; m_ok = 0;
            end
        end
        if ((seq || dur) && m_errs < 255) m_errs++;
        e = '{phase: m_phase, seq: seq, dur: dur, done: done, last: m_last, errc: m_errs};
    endtask

    task automatic drive(input logic [2:0] c);
        exp_t e;
        @(negedge clk_i);
        {red_i, yellow_i, green_i} = c;
        model(c, e);
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        chk("phase", int'(phase_o), e.phase);
        chk("seq_err", int'(seq_err_o), e.seq);
        chk("dur_err", int'(dur_err_o), e.dur);
        chk("cycle_done", int'(cycle_done_o), e.done);
        chk("last_dur", int'(last_dur_o), e.last);
        chk("err_count", int'(err_count_o), e.errc);
        if (cycle_done_o) done_seen++;
    endtask

    task automatic drive_n(input logic [2:0] c, input int n);
        for (int i = 0; i < n; i++) drive(c);
    endtask

    // YELLOW_RED, green group and YELLOW of one nominal cycle
    task automatic cycle_tail();
        drive_n(3'b110, 3);
        drive_n(3'b001, 3);
        drive(3'b000); drive(3'b001); drive(3'b000);
        drive_n(3'b010, 3);
    endtask

    initial begin
        #12;
        chk("rst_phase", int'(phase_o), 0);
        chk("rst_last", int'(last_dur_o), 0);
        chk("rst_errc", int'(err_count_o), 0);
        chk("rst_pulses", int'({seq_err_o, dur_err_o, cycle_done_o}), 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // nominal cycles: first unarmed, second completes
        drive(3'b000);
        drive_n(3'b100, 3); cycle_tail();
        drive_n(3'b100, 3); cycle_tail();
        drive(3'b100);
        chk("nominal_done_count", done_seen, 1);
        chk("nominal_last", int'(last_dur_o), 3);
        chk("nominal_errc", int'(err_count_o), 0);

        // RED too long in an armed cycle
        drive_n(3'b100, 3);
        drive(3'b110);
        chk("red4_dur_err", int'(dur_err_o), 1);
        chk("red4_last", int'(last_dur_o), 4);
        chk("red4_errc", int'(err_count_o), 1);
        drive_n(3'b110, 2);
        drive_n(3'b001, 3); drive(3'b000); drive(3'b001); drive(3'b000);
        drive_n(3'b010, 3);
        drive(3'b100);
        chk("red4_no_done", int'(cycle_done_o), 0);

        // illegal code during YELLOW_RED, then ignored codes and resync
        drive_n(3'b100, 2); drive(3'b110); drive(3'b101);
        chk("illegal_seq", int'(seq_err_o), 1);
        chk("illegal_phase", int'(phase_o), 0);
        drive(3'b010); drive(3'b001); drive(3'b100);
        chk("resync_phase", int'(phase_o), 1);

        // repeated blink-off, then direct jump RED -> green
        drive_n(3'b100, 2); cycle_tail();
        drive(3'b100);
        drive_n(3'b100, 2); drive_n(3'b110, 3); drive_n(3'b001, 3);
        drive(3'b000); drive(3'b000);
        chk("blink_rep_seq", int'(seq_err_o), 1);
        drive(3'b100); drive(3'b001);
        chk("jump_seq", int'(seq_err_o), 1);
        chk("jump_phase", int'(phase_o), 0);

        // error counter saturation
        for (int i = 0; i < 300; i++) begin drive(3'b111); drive(3'b100); end
        chk("errc_sat", int'(err_count_o), 255);

        // asynchronous reset mid-GREEN
        drive_n(3'b100, 1); drive_n(3'b110, 3); drive_n(3'b001, 2);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_phase", int'(phase_o), 0);
        chk("arst_errc", int'(err_count_o), 0);
        chk("arst_last", int'(last_dur_o), 0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(3'b001);
        chk("post_rst_ignored", int'(phase_o), 0);
        drive(3'b100);
        chk("post_rst_sync", int'(phase_o), 1);

        // saturating duration counter on an armed RED
        drive_n(3'b100, 2); cycle_tail();
        drive_n(3'b100, 2100);
        drive(3'b110);
        chk("sat_last", int'(last_dur_o), 2047);
        chk("sat_dur_err", int'(dur_err_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
